// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between producer channels, the MMIO slot and the FIFO core write port.
// Channel handshake: req[i] is valid and gnt[i] is ready; a beat moves when both are high in a cycle.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic                          cs;
  logic                          read;
  logic                          write;
  logic [4:0]                    addr;
  logic [31:0]                   wr_data;
  logic [31:0]                   rd_data;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_w_data;
  logic                          fifo_full;
  logic                          dbg_state;

  modport slave (
    input  cs, read, write, addr, wr_data, req, req_data, req_last, fifo_full,
    output rd_data, gnt, fifo_wr, fifo_w_data, dbg_state
  );

  modport master (
    output cs, read, write, addr, wr_data, req, req_data, req_last, fifo_full,
    input  rd_data, gnt, fifo_wr, fifo_w_data, dbg_state
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ channels.
// Optional accepted-beat counter at slot addr 2 is built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               reset,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [OW-1:0]      r_owner, w_owner_nxt;
  logic [OW-1:0]      r_last_owner, w_last_owner_nxt;
  logic [3:0]         r_beat_cnt, w_beat_cnt_nxt;
  logic [NUM_REQ-1:0] r_mask;
  logic [NUM_REQ-1:0] w_elig;
  logic [OW-1:0]      w_pick;
  logic               w_pick_vld;
  logic               w_accept;
  logic               w_reg_wr;
  logic [31:0]        w_wr_cnt;
  logic               w_unused_bits;

  assign w_elig   = bus.req & r_mask;
  assign w_reg_wr = bus.cs & bus.write;
  assign w_accept = (r_state == S_BURST) & bus.req[r_owner] & r_mask[r_owner] & ~bus.fifo_full;

  // First eligible channel scanning upward from the one after the previous owner.
  always_comb begin
    int idx;
    idx        = 0;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last_owner) + k) % NUM_REQ;
      if (!w_pick_vld && w_elig[idx]) begin
        w_pick     = OW'(idx);
        w_pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_beat_cnt_nxt   = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld && !bus.fifo_full) begin
          w_owner_nxt    = w_pick;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = S_BURST;
        end
      end
      S_BURST: begin
        if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + 4'd1;
          if (bus.req_last[r_owner] || (r_beat_cnt + 4'd1 == 4'(MAX_BURST))) begin
            w_state_nxt      = S_IDLE;
            w_last_owner_nxt = r_owner;
          end
        end else if (!bus.req[r_owner] || !r_mask[r_owner]) begin
          // A full FIFO alone never ends the tenure; only a withdrawn or masked owner does.
          w_state_nxt      = S_IDLE;
          w_last_owner_nxt = r_owner;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt = '0;
    if (w_accept) bus.gnt[r_owner] = 1'b1;
  end

  assign bus.fifo_wr     = w_accept;
  assign bus.fifo_w_data = w_accept ? bus.req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH]
                                    : '0;
  assign bus.dbg_state   = (r_state == S_BURST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '1;
    end else if (w_reg_wr && bus.addr[1:0] == 2'd0) begin
      r_mask <= bus.wr_data[NUM_REQ-1:0];
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] r_wr_cnt;

  // Clear wins over a same-cycle increment; the count sticks at all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_cnt <= '0;
    end else if (w_reg_wr && bus.addr[1:0] == 2'd2) begin
      r_wr_cnt <= '0;
    end else if (w_accept && r_wr_cnt != 32'hFFFF_FFFF) begin
      r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  assign w_wr_cnt = r_wr_cnt;
`else
  assign w_wr_cnt = '0;
`endif

  always_comb begin
    bus.rd_data = '0;
    case (bus.addr[1:0])
      2'd0: bus.rd_data[NUM_REQ-1:0] = r_mask;
      2'd1: begin
        bus.rd_data[3:0]  = 4'(r_owner);
        bus.rd_data[4]    = (r_state == S_BURST);
        bus.rd_data[8:5]  = r_beat_cnt;
        bus.rd_data[31]   = bus.fifo_full;
      end
      2'd2: bus.rd_data = w_wr_cnt;
      default: bus.rd_data = '0;
    endcase
  end

  assign w_unused_bits = &{1'b0, bus.read, bus.addr[4:2], bus.wr_data};

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: channel packet queues, a transaction-level arbiter model,
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_fifo_wr_arbiter;
  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Pending packet beats per channel: {last, data}
  logic [DW:0]    ch_q [NR][$];
  logic [NR-1:0]  drop;

  // Model: who owns the port, whose turn came last, beats taken this tenure.
  bit             m_busy;
  int             m_owner;
  int             m_last;
  int             m_cnt;
  logic [NR-1:0]  m_mask;
  logic [31:0]    m_stat;

  logic [NR-1:0]  gnt_log [$];
  logic [DW-1:0]  wd_log  [$];
  logic [31:0]    obs_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int ch, input logic [DW-1:0] data, input bit last);
    ch_q[ch].push_back({last, data});
  endtask

  task automatic slot_idle();
    bus.cs      = 1'b0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.addr    = 5'd0;
    bus.wr_data = 32'd0;
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = NR - 1;
    m_cnt   = 0;
    m_mask  = '1;
    m_stat  = 32'd0;
  endtask

  // Called at a falling edge; leaves the DUT out of reset at a falling edge.
  task automatic apply_reset();
    reset = 1'b0;
    slot_idle();
    bus.req       = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    drop          = '0;
    for (int i = 0; i < NR; i++) ch_q[i].delete();
    model_reset();
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
    check("rst_fifo_w_data", 32'(bus.fifo_w_data), 32'd0);
    bus.addr = 5'd0; #1;
    check("rst_mask", bus.rd_data, 32'h0000_000F);
    bus.addr = 5'd1; #1;
    check("rst_status", bus.rd_data, 32'd0);
    bus.addr = 5'd2; #1;
    check("rst_count", bus.rd_data, 32'd0);
    bus.addr = 5'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock: present channel heads, compare outputs with the model, advance the model.
  task automatic step();
    logic [NR-1:0]    r;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    logic             acc;
    logic [31:0]      exp_rd;
    r = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      d[i*DW +: DW] = DW'($urandom);
      if (ch_q[i].size() > 0 && !drop[i]) begin
        r[i]          = 1'b1;
        d[i*DW +: DW] = ch_q[i][0][DW-1:0];
        l[i]          = ch_q[i][0][DW];
      end
    end
    bus.req      = r;
    bus.req_data = d;
    bus.req_last = l;
    #1;
    acc = m_busy && r[m_owner] && m_mask[m_owner] && !bus.fifo_full;
    check("gnt", 32'(bus.gnt), acc ? (32'd1 << m_owner) : 32'd0);
    check("fifo_wr", 32'(bus.fifo_wr), 32'(acc));
    check("fifo_w_data", 32'(bus.fifo_w_data), acc ? 32'(d[m_owner*DW +: DW]) : 32'd0);
    case (bus.addr[1:0])
      2'd0:    exp_rd = 32'(m_mask);
      2'd1:    exp_rd = {bus.fifo_full, 22'd0, m_cnt[3:0], m_busy, m_owner[3:0]};
      2'd2:    exp_rd = m_stat;
      default: exp_rd = 32'd0;
    endcase
    check("rd_data", bus.rd_data, exp_rd);
    check("busy", 32'(bus.dbg_state), 32'(m_busy));
    obs_rd = bus.rd_data;
    gnt_log.push_back(bus.gnt);
    if (bus.fifo_wr) wd_log.push_back(bus.fifo_w_data);
    @(posedge clk);
    if (!m_busy) begin
      if ((r & m_mask) != '0 && !bus.fifo_full) begin
        for (int k = 1; k <= NR; k++) begin
          int c;
          c = (m_last + k) % NR;
          if (r[c] && m_mask[c]) begin
            m_owner = c;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (acc) begin
      void'(ch_q[m_owner].pop_front());
      m_cnt++;
      if (l[m_owner] || m_cnt == MAXB) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end else if (!r[m_owner] || !m_mask[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end
`ifdef FIFO_ARB_STATS_EN
    if (bus.cs && bus.write && bus.addr[1:0] == 2'd2) m_stat = 32'd0;
    else if (acc && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 32'd1;
`endif
    if (bus.cs && bus.write && bus.addr[1:0] == 2'd0) m_mask = bus.wr_data[NR-1:0];
    @(negedge clk);
  endtask

  task automatic check_logs(input string name, input logic [NR-1:0] eg[$], input logic [DW-1:0] ed[$]);
    for (int i = 0; i < eg.size(); i++)
      check($sformatf("%s_gnt[%0d]", name, i),
            (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hDEAD_BEEF, 32'(eg[i]));
    check($sformatf("%s_nwrites", name), 32'(wd_log.size()), 32'(ed.size()));
    for (int i = 0; i < ed.size(); i++)
      check($sformatf("%s_data[%0d]", name, i),
            (i < wd_log.size()) ? 32'(wd_log[i]) : 32'hDEAD_BEEF, 32'(ed[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] eg[$];
    logic [DW-1:0] ed[$];
    logic [31:0]   exp_cnt;
    reset = 1'b0;
    @(negedge clk);

    // Round-robin between ch0 and ch2 with two-beat packets
    apply_reset();
    gnt_log.delete(); wd_log.delete();
    push_beat(0, 8'h01, 0); push_beat(0, 8'h02, 1);
    push_beat(0, 8'h03, 0); push_beat(0, 8'h04, 1);
    push_beat(2, 8'h21, 0); push_beat(2, 8'h22, 1);
    for (int i = 0; i < 9; i++) step();
    eg = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h1, 4'h1};
    ed = '{8'h01, 8'h02, 8'h21, 8'h22, 8'h03, 8'h04};
    check_logs("rr", eg, ed);

    // Burst bound: ch1 ten beats against ch3
    apply_reset();
    gnt_log.delete(); wd_log.delete();
    for (int i = 0; i < 10; i++) push_beat(1, 8'h10 + 8'(i), i == 9);
    push_beat(3, 8'h30, 0); push_beat(3, 8'h31, 1);
    for (int i = 0; i < 18; i++) step();
    eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0,
           4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
    ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31,
           8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    check_logs("burst", eg, ed);

    // FIFO full for three cycles mid-burst
    apply_reset();
    gnt_log.delete(); wd_log.delete();
    for (int i = 0; i < 4; i++) push_beat(0, 8'hA0 + 8'(i), i == 3);
    for (int i = 0; i < 9; i++) begin
      bus.fifo_full = (i >= 3 && i <= 5);
      bus.addr      = 5'd1;
      step();
      if (i >= 3 && i <= 5) begin
        check("full_busy", 32'(obs_rd[4]), 32'd1);
        check("full_flag", 32'(obs_rd[31]), 32'd1);
      end
    end
    bus.fifo_full = 1'b0;
    eg = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_logs("full", eg, ed);

    // Mask write 0x2 during a ch0 burst
    apply_reset();
    gnt_log.delete(); wd_log.delete();
    for (int i = 0; i < 8; i++) push_beat(0, 8'(i), i == 7);
    push_beat(1, 8'h50, 0); push_beat(1, 8'h51, 1);
    for (int i = 0; i < 9; i++) begin
      slot_idle();
      if (i == 2) begin
        bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 5'd0; bus.wr_data = 32'h2;
      end
      step();
    end
    slot_idle();
    eg = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
    ed = '{8'h00, 8'h01, 8'h50, 8'h51};
    check_logs("mask", eg, ed);

    // Beat counter: seven beats, then a clear coinciding with a beat
    apply_reset();
    for (int i = 0; i < 7; i++) push_beat(1, 8'h60 + 8'(i), i == 6);
    for (int i = 0; i < 10; i++) step();
    bus.addr = 5'd2;
    step();
`ifdef FIFO_ARB_STATS_EN
    exp_cnt = 32'd7;
`else
    exp_cnt = 32'd0;
`endif
    check("count_7", obs_rd, exp_cnt);
    for (int i = 0; i < 3; i++) push_beat(1, 8'h70 + 8'(i), i == 2);
    step();
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 5'd2; bus.wr_data = 32'h1234;
    step();
    slot_idle();
    bus.addr = 5'd2;
    step();
    check("count_clear", obs_rd, 32'd0);
    slot_idle();

    // Randomized traffic with one reset in the middle
    apply_reset();
    gnt_log.delete(); wd_log.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) apply_reset();
      if ($urandom_range(0, 2) == 0) begin
        int ch;
        int len;
        ch = $urandom_range(0, NR - 1);
        if (ch_q[ch].size() < 8) begin
          len = $urandom_range(1, 6);
          for (int j = 0; j < len; j++) push_beat(ch, DW'($urandom), j == len - 1);
        end
      end
      bus.fifo_full = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NR; i++) drop[i] = ($urandom_range(0, 9) == 0);
      bus.cs      = ($urandom_range(0, 3) == 0);
      bus.write   = bus.cs && ($urandom_range(0, 1) == 1);
      bus.read    = bus.cs && !bus.write;
      bus.addr    = 5'($urandom);
      bus.wr_data = $urandom;
      if (bus.write && bus.addr[1:0] == 2'd0 && bus.wr_data[NR-1:0] == '0)
        bus.wr_data[NR-1:0] = '1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
